// File: rtl/mem_writeback_stage.sv
// Memory/writeback stage: captures the execute/memory request, extends load data and drives the
// register-file write port. Define WB_FORWARD_EN to add the execute-stage bypass outputs.
module mem_writeback_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic              in_is_load,
   input  logic              in_writes_rd,
   input  logic              in_load_unsigned,
   input  logic [4:0]        in_access_code,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic [1:0]        prev_r,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              load_pending,
   output logic [CNT_W-1:0]  retired_count
`ifdef WB_FORWARD_EN
  ,output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_rd,
   output logic [DATA_W-1:0] fwd_data
`endif
);

   typedef struct packed {
      logic              valid;
      logic              is_load;
      logic              writes_rd;
      logic              load_unsigned;
      logic              store;
      logic [3:0]        byte_en;
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] alu;
   } stage_t;

   stage_t            stage_q, stage_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] load_data;

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      stage_d = stage_q;
      count_d = count_q;
      if (!stall) begin
         stage_d.valid         = in_valid & ~flush;
         stage_d.is_load       = in_is_load;
         stage_d.writes_rd     = in_writes_rd;
         stage_d.load_unsigned = in_load_unsigned;
         stage_d.store         = in_access_code[4];
         stage_d.byte_en       = in_access_code[3:0];
         stage_d.rd            = in_rd;
         stage_d.alu           = in_alu_result;
         if (stage_q.valid) count_d = count_q + CNT_W'(1);
      end
   end

   // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         stage_q <= '0;
         count_q <= '0;
      end else begin
         stage_q <= stage_d;
         count_q <= count_d;
      end
   end

   // mem_read_data arrives already rotated: the addressed byte sits in the top lane.
   always_comb begin
      load_data = mem_read_data;
      case (stage_q.byte_en)
         4'b1000: load_data = {{(DATA_W-8){~stage_q.load_unsigned & mem_read_data[DATA_W-1]}},
                               mem_read_data[DATA_W-1 -: 8]};
         4'b1100: load_data = {{(DATA_W-16){~stage_q.load_unsigned & mem_read_data[DATA_W-1]}},
                               mem_read_data[DATA_W-1 -: 16]};
         default: load_data = mem_read_data;
      endcase
   end

   // Reset gates the write so a load caught mid-flight never reaches the register file.
   always_comb begin
      rf_we         = stage_q.valid & stage_q.writes_rd & ~stage_q.store &
                      (stage_q.rd != '0) & ~stall & ~reset;
      rf_waddr      = stage_q.rd;
      rf_wdata      = stage_q.is_load ? load_data : stage_q.alu;
      prev_r        = stage_q.alu[1:0];
      load_pending  = stage_q.valid & stage_q.is_load;
      retired_count = count_q;
   end

`ifdef WB_FORWARD_EN
   assign fwd_valid = rf_we;
   assign fwd_rd    = rf_waddr;
   assign fwd_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Directed bench for mem_writeback_stage; a second instance with a 4-bit counter exercises wrap.
module tb_mem_writeback_stage;

   logic        clock = 1'b0;
   logic        reset, stall, flush;
   logic        in_valid, in_is_load, in_writes_rd, in_load_unsigned;
   logic [4:0]  in_access_code;
   logic [4:0]  in_rd;
   logic [31:0] in_alu_result, mem_read_data;

   logic [1:0]  prev_r, prev_r_w;
   logic        rf_we, rf_we_w;
   logic [4:0]  rf_waddr, rf_waddr_w;
   logic [31:0] rf_wdata, rf_wdata_w;
   logic        load_pending, load_pending_w;
   logic [31:0] retired_count;
   logic [3:0]  retired_count_w;
`ifdef WB_FORWARD_EN
   logic        fwd_valid, fwd_valid_w;
   logic [4:0]  fwd_rd, fwd_rd_w;
   logic [31:0] fwd_data, fwd_data_w;
`endif

   int n_asserts = 0;
   int n_fails   = 0;

   always #5 clock = ~clock;

   mem_writeback_stage dut (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_is_load(in_is_load), .in_writes_rd(in_writes_rd),
      .in_load_unsigned(in_load_unsigned), .in_access_code(in_access_code),
      .in_rd(in_rd), .in_alu_result(in_alu_result), .mem_read_data(mem_read_data),
      .prev_r(prev_r), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .load_pending(load_pending), .retired_count(retired_count)
`ifdef WB_FORWARD_EN
     ,.fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
   );

   mem_writeback_stage #(.CNT_W(4)) dut_w (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_is_load(in_is_load), .in_writes_rd(in_writes_rd),
      .in_load_unsigned(in_load_unsigned), .in_access_code(in_access_code),
      .in_rd(in_rd), .in_alu_result(in_alu_result), .mem_read_data(mem_read_data),
      .prev_r(prev_r_w), .rf_we(rf_we_w), .rf_waddr(rf_waddr_w), .rf_wdata(rf_wdata_w),
      .load_pending(load_pending_w), .retired_count(retired_count_w)
`ifdef WB_FORWARD_EN
     ,.fwd_valid(fwd_valid_w), .fwd_rd(fwd_rd_w), .fwd_data(fwd_data_w)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_instr(input bit v, input bit ld, input bit wr, input bit uns,
                            input logic [4:0] code, input logic [4:0] rd, input logic [31:0] alu);
      in_valid         = v;
      in_is_load       = ld;
      in_writes_rd     = wr;
      in_load_unsigned = uns;
      in_access_code   = code;
      in_rd            = rd;
      in_alu_result    = alu;
   endtask

   task automatic set_idle();
      set_instr(1'b0, 1'b0, 1'b0, 1'b0, 5'b0_0000, 5'd0, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; mem_read_data = 32'h0;
      set_idle();
      repeat (2) step();
      check("rst_prev_r",  prev_r, 0);
      check("rst_rf_we",   rf_we, 0);
      check("rst_waddr",   rf_waddr, 0);
      check("rst_wdata",   rf_wdata, 0);
      check("rst_pending", load_pending, 0);
      check("rst_retired", retired_count, 0);
      reset = 1'b0;

      // ALU op to r5
      set_instr(1, 0, 1, 0, 5'b0_0000, 5'd5, 32'h1234_5678);
      step();
      set_idle(); #1;
      check("alu_we",      rf_we, 1);
      check("alu_waddr",   rf_waddr, 5);
      check("alu_wdata",   rf_wdata, 32'h1234_5678);
      check("alu_pending", load_pending, 0);
      check("alu_retired", retired_count, 0);

      // signed byte load
      set_instr(1, 1, 1, 0, 5'b0_1000, 5'd3, 32'h0000_0100);
      step();
      mem_read_data = 32'h80AA_BBCC;
      set_instr(1, 1, 1, 1, 5'b0_1000, 5'd3, 32'h0000_0101);
      #1;
      check("sb_wdata",   rf_wdata, 32'hFFFF_FF80);
      check("sb_we",      rf_we, 1);
      check("sb_pending", load_pending, 1);
      check("sb_retired", retired_count, 1);
      check("sb_prev_r",  prev_r, 0);

      // unsigned byte load
      step();
      set_instr(1, 1, 1, 0, 5'b0_1100, 5'd4, 32'h0000_0203);
      #1;
      check("ub_wdata",  rf_wdata, 32'h0000_0080);
      check("ub_prev_r", prev_r, 1);

      // signed half load, offset 3
      step();
      mem_read_data = 32'h7FFE_0000;
      set_instr(1, 0, 1, 0, 5'b1_1111, 5'd7, 32'h0000_0040);
      #1;
      check("sh_wdata",   rf_wdata, 32'h0000_7FFE);
      check("sh_prev_r",  prev_r, 3);
      check("sh_waddr",   rf_waddr, 4);
      check("sh_retired", retired_count, 3);

      // store
      step();
      set_instr(1, 1, 1, 1, 5'b0_0011, 5'd9, 32'h0000_0000);
      #1;
      check("st_we",      rf_we, 0);
      check("st_pending", load_pending, 0);
      check("st_waddr",   rf_waddr, 7);
      check("st_retired", retired_count, 4);

      // load with an odd enable pattern behaves as word
      step();
      mem_read_data = 32'hDEAD_BEEF;
      set_instr(1, 0, 1, 0, 5'b0_0000, 5'd0, 32'hFFFF_FFFF);
      #1;
      check("odd_wdata",   rf_wdata, 32'hDEAD_BEEF);
      check("odd_we",      rf_we, 1);
      check("odd_retired", retired_count, 5);

      // ALU op writing r0
      step();
      flush = 1'b1;
      set_instr(1, 0, 1, 0, 5'b0_0000, 5'd6, 32'h0000_0055);
      #1;
      check("r0_we",    rf_we, 0);
      check("r0_wdata", rf_wdata, 32'hFFFF_FFFF);

      // flushed instruction
      step();
      flush = 1'b0;
      set_idle(); #1;
      check("fl_we",      rf_we, 0);
      check("fl_waddr",   rf_waddr, 6);
      check("fl_retired", retired_count, 7);
      set_instr(1, 1, 1, 0, 5'b0_1000, 5'd10, 32'h0000_0002);
      step();
      check("fl_retired2", retired_count, 7);

      // load held by a 3-cycle stall; flush during stall is ignored
      mem_read_data = 32'h7F00_0000;
      stall = 1'b1;
      flush = 1'b1;
      set_instr(1, 0, 1, 0, 5'b0_0000, 5'd11, 32'h0000_0099);
      #1;
      check("stl_we",      rf_we, 0);
      check("stl_wdata",   rf_wdata, 32'h0000_007F);
      check("stl_pending", load_pending, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         flush = 1'b0;
         check("stl_hold_waddr",   rf_waddr, 10);
         check("stl_hold_prev_r",  prev_r, 2);
         check("stl_hold_we",      rf_we, 0);
         check("stl_hold_pending", load_pending, 1);
         check("stl_hold_retired", retired_count, 7);
      end
      stall = 1'b0;
      set_idle(); #1;
      check("stl_rel_we",    rf_we, 1);
      check("stl_rel_wdata", rf_wdata, 32'h0000_007F);
      step();
      check("stl_rel_retired", retired_count, 8);

      // reset while a load is pending
      set_instr(1, 1, 1, 0, 5'b0_1111, 5'd12, 32'h0000_0001);
      step();
      set_idle();
      mem_read_data = 32'hCAFE_F00D;
      #1;
      check("rml_pending", load_pending, 1);
      check("rml_cnt_w",   retired_count_w, 8);
      reset = 1'b1;
      step();
      check("rml_we",      rf_we, 0);
      check("rml_pending", load_pending, 0);
      check("rml_waddr",   rf_waddr, 0);
      check("rml_wdata",   rf_wdata, 0);
      check("rml_prev_r",  prev_r, 0);
      check("rml_retired", retired_count, 0);
      reset = 1'b0;

      // counter wrap on the 4-bit instance
      set_instr(1, 0, 1, 0, 5'b0_0000, 5'd1, 32'h0000_0001);
      repeat (15) step();
      set_idle();
      step();
      check("wrap_max_w", retired_count_w, 4'hF);
      check("wrap_max",   retired_count, 15);
      set_instr(1, 0, 1, 0, 5'b0_0000, 5'd1, 32'h0000_0001);
      step();
      set_idle();
      step();
      check("wrap_zero_w", retired_count_w, 0);
      check("wrap_16",     retired_count, 16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
